// File: rtl/antirrebote_botones.sv
// Five-button synchronizer and debouncer.
// Clean levels plus one-cycle press/release pulses, all on clk.
module antirrebote_botones #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic       btnL,
  output logic       btnC,
  output logic       btnU,
  output logic       btnD,
  output logic       btnR,
  output logic [4:0] btn_level,
  output logic [4:0] btn_rise,
  output logic [4:0] btn_fall,
  output logic       btn_any
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    lvl;
  logic [CW-1:0] cnt [5];
  logic [4:0]    accept;
  logic [4:0]    rise_d;
  logic [4:0]    fall_d;

  // A bit is accepted once s2 has differed from lvl for the full window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 5; i++) begin
      accept[i] = (s2[i] != lvl[i]) && (cnt[i] == LAST);
    end
    rise_d = accept & s2;
    fall_d = accept & ~s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      lvl      <= '0;
      btn_rise <= '0;
      btn_fall <= '0;
      btn_any  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1       <= btn_raw;
      s2       <= s1;
      btn_rise <= rise_d;
      btn_fall <= fall_d;
      btn_any  <= |rise_d;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_level = lvl;
  assign btnL      = lvl[4];
  assign btnC      = lvl[3];
  assign btnU      = lvl[2];
  assign btnD      = lvl[1];
  assign btnR      = lvl[0];

endmodule

// File: tb/tb_antirrebote_botones.sv
// Scoreboard bench for antirrebote_botones at DEBOUNCE_CYCLES = 4.
// Expected pulse events are queued when stimulus is driven.
module tb_antirrebote_botones;

  localparam int DC = 4;
  // Drive at a negedge -> s1 captures on the next edge k -> output at k+1+DC.
  localparam int LAT = DC + 2;

  typedef struct {
    int         cyc;
    logic [4:0] rise;
    logic [4:0] fall;
    logic [4:0] lvl;
    logic       any;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic       btnL, btnC, btnU, btnD, btnR;
  logic [4:0] btn_level;
  logic [4:0] btn_rise;
  logic [4:0] btn_fall;
  logic       btn_any;

  int  cyc;
  int  errors;
  int  checks;
  ev_t q[$];

  antirrebote_botones #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btnL      (btnL),
    .btnC      (btnC),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnR      (btnR),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_any   (btn_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [4:0] r, input logic [4:0] f,
                         input logic [4:0] l);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.rise = r;
    e.fall = f;
    e.lvl  = l;
    e.any  = |r;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lvl"}, 32'(btn_level), 32'd0);
    chk({tag, "_btns"}, 32'({btnL, btnC, btnU, btnD, btnR}), 32'd0);
    chk({tag, "_rise"}, 32'(btn_rise), 32'd0);
    chk({tag, "_fall"}, 32'(btn_fall), 32'd0);
    chk({tag, "_any"}, 32'(btn_any), 32'd0);
  endtask

  // Any visible pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (btn_rise != 0 || btn_fall != 0 || btn_any) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {btn_rise, btn_fall, 22'd0},
            {btn_any, 31'd0} & 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_cyc", 32'(cyc), 32'(e.cyc));
        chk("ev_rise", 32'(btn_rise), 32'(e.rise));
        chk("ev_fall", 32'(btn_fall), 32'(e.fall));
        chk("ev_any", 32'(btn_any), 32'(e.any));
        chk("ev_lvl", 32'(btn_level), 32'(e.lvl));
        chk("ev_btns", 32'({btnL, btnC, btnU, btnD, btnR}), 32'(e.lvl));
      end
    end
  end

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    btn_raw = 5'b11111;

    // Buttons held through reset
    wait_cyc(3);
    #1 chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    push_ev(5'b11111, 5'b00000, 5'b11111);
    wait_cyc(10);
    chk("held_lvl", 32'(btn_level), 32'h1f);
    btn_raw = 5'b00000;
    push_ev(5'b00000, 5'b11111, 5'b00000);
    wait_cyc(10);

    // Clean press and release of C
    btn_raw = 5'b01000;
    push_ev(5'b01000, 5'b00000, 5'b01000);
    wait_cyc(10);
    chk("c_high", 32'(btnC), 32'd1);
    btn_raw = 5'b00000;
    push_ev(5'b00000, 5'b01000, 5'b00000);
    wait_cyc(10);
    chk("c_low", 32'(btnC), 32'd0);

    // Bounce on R, then stable high
    btn_raw = 5'b00001; wait_cyc(1);
    btn_raw = 5'b00000; wait_cyc(1);
    btn_raw = 5'b00001; wait_cyc(1);
    btn_raw = 5'b00000; wait_cyc(1);
    btn_raw = 5'b00001;
    push_ev(5'b00001, 5'b00000, 5'b00001);
    wait_cyc(10);
    btn_raw = 5'b00000;
    push_ev(5'b00000, 5'b00001, 5'b00000);
    wait_cyc(10);

    // Three-cycle glitch on U is rejected
    btn_raw = 5'b00100; wait_cyc(3);
    btn_raw = 5'b00000; wait_cyc(12);
    chk("glitch_lvl", 32'(btn_level), 32'd0);

    // L and D together
    btn_raw = 5'b10010;
    push_ev(5'b10010, 5'b00000, 5'b10010);
    wait_cyc(10);
    btn_raw = 5'b00000;
    push_ev(5'b00000, 5'b10010, 5'b00000);
    wait_cyc(10);

    // Reset while L is mid-count, with R already accepted
    btn_raw = 5'b00001;
    push_ev(5'b00001, 5'b00000, 5'b00001);
    wait_cyc(10);
    btn_raw = 5'b10001;
    wait_cyc(4);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    wait_cyc(2);
    rst_n = 1'b1;
    push_ev(5'b10001, 5'b00000, 5'b10001);
    wait_cyc(10);
    btn_raw = 5'b00000;
    push_ev(5'b00000, 5'b10001, 5'b00000);
    wait_cyc(10);

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
